// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types; the fetch queue entry and its default depth live here.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word insn;
    rv32i_word pred;
  } fq_entry_t;

  localparam int FQ_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_queue.sv
// IF->ID instruction buffer. In-order FIFO with a flush that toggles a 1-bit epoch
// so wrong-path fetches still in flight are dropped when they return.
module fetch_queue
  import rv32i_types::*;
#(
  parameter  int DEPTH = FQ_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enq_valid_i,
  input  logic [31:0]      enq_pc_i,
  input  logic [31:0]      enq_insn_i,
  input  logic [31:0]      enq_pred_i,
  input  logic             enq_epoch_i,
  output logic             enq_ready_o,
  output logic             deq_valid_o,
  output logic [31:0]      deq_pc_o,
  output logic [31:0]      deq_insn_o,
  output logic [31:0]      deq_pred_o,
  input  logic             deq_ready_i,
  input  logic             flush_i,
  output logic             epoch_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  fq_entry_t        mem [DEPTH];
  fq_entry_t        head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             epoch_q, epoch_d;
  logic             full, empty, enq_fire, deq_fire;

  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    enq_fire = enq_valid_i && !full && !flush_i && (enq_epoch_i == epoch_q);
    deq_fire = !empty && deq_ready_i && !flush_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    epoch_d  = epoch_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      epoch_d  = !epoch_q;
    end else begin
      // Pointers wrap for free because DEPTH is a power of two.
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      epoch_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      epoch_q  <= epoch_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_fire) mem[wr_ptr_q] <= '{pc: enq_pc_i, insn: enq_insn_i, pred: enq_pred_i};
  end

  // Data is gated by occupancy so stale storage never reaches ID and reset reads as zero.
  always_comb begin
    head        = mem[rd_ptr_q];
    enq_ready_o = !full;
    deq_valid_o = !empty;
    deq_pc_o    = empty ? '0 : head.pc;
    deq_insn_o  = empty ? '0 : head.insn;
    deq_pred_o  = empty ? '0 : head.pred;
    epoch_o     = epoch_q;
    count_o     = count_q;
  end

  a_count_le_depth: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= FULL_CNT);
  a_no_write_full:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(enq_fire && full));
  a_empty_invalid:  assert property (@(posedge clk_i) disable iff (!rst_ni) (count_o == '0) |-> !deq_valid_o);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed vectors for the fetch queue, then a randomized run against a queue model.
module tb_fetch_queue;
  import rv32i_types::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enq_valid_i = 1'b0;
  logic [31:0] enq_pc_i = '0, enq_insn_i = '0, enq_pred_i = '0;
  logic        enq_epoch_i = 1'b0;
  logic        enq_ready_o, deq_valid_o, deq_ready_i = 1'b0, flush_i = 1'b0, epoch_o;
  logic [31:0] deq_pc_o, deq_insn_o, deq_pred_o;
  logic [2:0]  count_o;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .enq_valid_i(enq_valid_i), .enq_pc_i(enq_pc_i), .enq_insn_i(enq_insn_i),
    .enq_pred_i(enq_pred_i), .enq_epoch_i(enq_epoch_i), .enq_ready_o(enq_ready_o),
    .deq_valid_o(deq_valid_o), .deq_pc_o(deq_pc_o), .deq_insn_o(deq_insn_o),
    .deq_pred_o(deq_pred_o), .deq_ready_i(deq_ready_i), .flush_i(flush_i),
    .epoch_o(epoch_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, cross a posedge, land on the next negedge.
  task automatic cyc(input logic ev, input logic [31:0] pc, input logic ep,
                     input logic dr, input logic fl);
    enq_valid_i = ev; enq_pc_i = pc; enq_insn_i = pc ^ 32'hA5A5_0000;
    enq_pred_i = pc + 32'd4; enq_epoch_i = ep; deq_ready_i = dr; flush_i = fl;
    @(posedge clk_i);
    @(negedge clk_i);
    enq_valid_i = 1'b0; deq_ready_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic vld,
                           input logic rdy, input logic ep);
    chk({tag, ".count"}, 32'(count_o), 32'(cnt));
    chk({tag, ".valid"}, 32'(deq_valid_o), 32'(vld));
    chk({tag, ".ready"}, 32'(enq_ready_o), 32'(rdy));
    chk({tag, ".epoch"}, 32'(epoch_o), 32'(ep));
  endtask

  fq_entry_t   model_q[$];
  logic        m_epoch;
  logic        r_ev, r_ep, r_dr, r_fl;
  logic [31:0] r_pc, r_insn, r_pred;

  initial begin
    // 1. reset values, read during reset
    #1;
    chk_state("reset", 0, 1'b0, 1'b1, 1'b0);
    chk("reset.pc", deq_pc_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 2. ordered fill, 5th enqueue refused
    cyc(1, 32'h60, 0, 0, 0);
    chk("fill1.pc", deq_pc_o, 32'h60);
    chk("fill1.count", 32'(count_o), 32'd1);
    cyc(1, 32'h64, 0, 0, 0);
    cyc(1, 32'h68, 0, 0, 0);
    cyc(1, 32'h6C, 0, 0, 0);
    chk_state("full", 4, 1'b1, 1'b0, 1'b0);
    cyc(1, 32'h70, 0, 0, 0);
    chk("over.count", 32'(count_o), 32'd4);
    chk("over.pc", deq_pc_o, 32'h60);

    // 3. full + simultaneous: only the pop fires
    cyc(1, 32'h70, 0, 1, 0);
    chk("fullpop.count", 32'(count_o), 32'd3);
    chk("drain.pc1", deq_pc_o, 32'h64);
    cyc(0, 0, 0, 1, 0);
    chk("drain.pc2", deq_pc_o, 32'h68);
    cyc(0, 0, 0, 1, 0);
    chk("drain.pc3", deq_pc_o, 32'h6C);
    chk("drain.insn3", deq_insn_o, 32'h6C ^ 32'hA5A5_0000);
    chk("drain.pred3", deq_pred_o, 32'h70);
    cyc(1, 32'h90, 0, 0, 0);
    chk("pre2.count", 32'(count_o), 32'd2);
    // rd_ptr=3 here, so this pop wraps it to 0
    cyc(1, 32'hA0, 0, 1, 0);
    chk("both1.count", 32'(count_o), 32'd2);
    chk("both1.pc", deq_pc_o, 32'h90);
    cyc(1, 32'hA4, 0, 1, 0);
    chk("both2.count", 32'(count_o), 32'd2);
    chk("both2.pc", deq_pc_o, 32'hA0);
    cyc(0, 0, 0, 1, 0);
    chk("wrap.pc", deq_pc_o, 32'hA4);
    cyc(0, 0, 0, 1, 0);
    chk_state("empty", 0, 1'b0, 1'b1, 1'b0);

    // 4. flush discards entries and the concurrent enqueue
    cyc(1, 32'hB0, 0, 0, 0);
    cyc(1, 32'hB4, 0, 0, 0);
    cyc(1, 32'hB8, 0, 0, 0);
    chk("pre_flush.count", 32'(count_o), 32'd3);
    cyc(1, 32'h80, 0, 1, 1);
    chk_state("flush", 0, 1'b0, 1'b1, 1'b1);
    chk("flush.pc", deq_pc_o, 32'h0);

    // 5. stale epoch dropped, current epoch accepted with one-cycle latency
    cyc(1, 32'h84, 0, 0, 0);
    chk("stale.count", 32'(count_o), 32'd0);
    enq_valid_i = 1'b1; enq_pc_i = 32'h200; enq_epoch_i = 1'b1;
    #1;
    chk("nobypass.valid", 32'(deq_valid_o), 32'd0);
    cyc(1, 32'h200, 1, 0, 0);
    chk("fresh.pc", deq_pc_o, 32'h200);
    chk("fresh.count", 32'(count_o), 32'd1);

    // async reset mid-cycle clears at once
    #2 rst_ni = 1'b0;
    #1;
    chk_state("midreset", 0, 1'b0, 1'b1, 1'b0);
    chk("midreset.pc", deq_pc_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 6. random run against a queue model
    m_epoch = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      chk("rnd.count", 32'(count_o), 32'(model_q.size()));
      chk("rnd.epoch", 32'(epoch_o), 32'(m_epoch));
      chk("rnd.valid", 32'(deq_valid_o), 32'(model_q.size() != 0));
      chk("rnd.ready", 32'(enq_ready_o), 32'(model_q.size() < DEPTH));
      if (model_q.size() != 0) begin
        chk("rnd.pc", deq_pc_o, model_q[0].pc);
        chk("rnd.insn", deq_insn_o, model_q[0].insn);
        chk("rnd.pred", deq_pred_o, model_q[0].pred);
      end
      r_ev = ($urandom_range(99) < 60);
      r_dr = ($urandom_range(99) < 50);
      r_fl = ($urandom_range(99) < 5);
      r_ep = ($urandom_range(99) < 10) ? !m_epoch : m_epoch;
      r_pc = $urandom; r_insn = $urandom; r_pred = $urandom;
      enq_valid_i = r_ev; enq_pc_i = r_pc; enq_insn_i = r_insn; enq_pred_i = r_pred;
      enq_epoch_i = r_ep; deq_ready_i = r_dr; flush_i = r_fl;
      if (r_fl) begin
        model_q.delete();
        m_epoch = !m_epoch;
      end else begin
        logic do_enq;
        do_enq = r_ev && (model_q.size() < DEPTH) && (r_ep == m_epoch);
        if (r_dr && model_q.size() != 0) void'(model_q.pop_front());
        if (do_enq) model_q.push_back('{pc: r_pc, insn: r_insn, pred: r_pred});
      end
      @(posedge clk_i);
      @(negedge clk_i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
